drop_scheduler: RTL

//   Consumes the periodic 0.5 s tick pulse and converts it into per-level gravity drop requests
//   for the piece-movement logic.
//   - Counts ticks against a level-dependent period and queues drop events in a saturating

---
 rtl/drop_scheduler_pkg.sv | 24 ++
 rtl/drop_scheduler_if.sv | 24 ++
 rtl/drop_scheduler_period_calc.sv | 20 ++
 rtl/drop_scheduler.sv | 115 +++++++++++
 4 files changed

// File: rtl/drop_scheduler_pkg.sv
// Shared timing definitions for the falling-piece gravity logic: the level-0
// drop period, the request FSM state type and the period rule itself.
package tetris_timing_pkg;

    localparam int TICKS_L0 = 8;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drop_state_t;

    // Ticks per drop: soft drop forces 1, higher levels shorten the period,
    // and anything at or beyond TICKS_L0 bottoms out at 1 rather than wrapping.
    function automatic int drop_period(input int level, input logic soft_drop, input int ticks_l0);
        if (soft_drop) begin
            return 1;
        end
        if (level < ticks_l0) begin
            return ticks_l0 - level;
        end
        return 1;
    endfunction

endpackage

// File: rtl/drop_scheduler_if.sv
// Handshake bundle between the drop scheduler and the piece controller.
// The scheduler drives the request and status; the controller returns drop_ack.
interface drop_scheduler_if #(
    parameter int PEND_W = 3
);
    logic              drop_req;
    logic              drop_ack;
    logic [PEND_W-1:0] pending;
    logic              overrun;

    modport master (
        output drop_req,
        output pending,
        output overrun,
        input  drop_ack
    );

    modport slave (
        input  drop_req,
        input  pending,
        input  overrun,
        output drop_ack
    );
endinterface

// File: rtl/drop_scheduler_period_calc.sv
// Combinational translation of level/soft_drop into the tick period used by
// the drop scheduler's tick counter.
module drop_period_calc
    import tetris_timing_pkg::*;
#(
    parameter int TICKS_L0_P = TICKS_L0,
    parameter int LEVEL_W    = 4,
    parameter int CNT_W      = 8
) (
    input  logic [LEVEL_W-1:0] level,
    input  logic               soft_drop,
    output logic [CNT_W-1:0]   period
);

    // Period is never zero and never wraps, so the counter compare stays simple.
    always_comb begin
        period = CNT_W'(drop_period(int'(level), soft_drop, TICKS_L0_P));
    end

endmodule

// File: rtl/drop_scheduler.sv
// Gravity drop scheduler: counts tick pulses against the level-dependent
// period, queues drop events in a saturating counter and hands each one to
// the piece controller through a req/ack handshake.
module drop_scheduler
    import tetris_timing_pkg::*;
#(
    parameter int TICKS_L0_P = TICKS_L0,
    parameter int LEVEL_W    = 4,
    parameter int CNT_W      = 8,
    parameter int PEND_W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [LEVEL_W-1:0] level,
    input  logic               soft_drop,
    input  logic               pause,
    input  logic               clear,
    drop_scheduler_if.master   bus
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]  tick_cnt;
    logic [CNT_W-1:0]  period;
    logic [CNT_W:0]    cnt_inc;
    logic [PEND_W-1:0] pending_q;
    logic              overrun_q;
    logic              qual_tick;
    logic              drop_event;
    logic              ack_taken;
    drop_state_t       state;
    drop_state_t       state_next;

    drop_period_calc #(
        .TICKS_L0_P (TICKS_L0_P),
        .LEVEL_W    (LEVEL_W),
        .CNT_W      (CNT_W)
    ) u_period (
        .level     (level),
        .soft_drop (soft_drop),
        .period    (period)
    );

    // A drop fires when the incremented count reaches or passes the period;
    // the >= keeps a mid-count period shrink from skipping the drop.
    always_comb begin
        cnt_inc    = {1'b0, tick_cnt} + {{CNT_W{1'b0}}, 1'b1};
        qual_tick  = tick & ~pause & ~clear;
        drop_event = qual_tick && (cnt_inc >= {1'b0, period});
        ack_taken  = (state == REQ) && bus.drop_ack;
    end

    // Tick counter: cleared on clear, advanced only by qualifying ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (clear) begin
            tick_cnt <= '0;
        end else if (qual_tick) begin
            tick_cnt <= drop_event ? '0 : cnt_inc[CNT_W-1:0];
        end
    end

    // Pending queue depth and sticky overrun; clear flushes the queue but
    // deliberately keeps the overrun record for the game logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            overrun_q <= 1'b0;
        end else if (clear) begin
            pending_q <= '0;
        end else begin
            unique case ({drop_event, ack_taken})
                2'b10: begin
                    if (pending_q == PEND_MAX) begin
                        overrun_q <= 1'b1;
                    end else begin
                        pending_q <= pending_q + PEND_ONE;
                    end
                end
                2'b01:   pending_q <= pending_q - PEND_ONE;
                default: pending_q <= pending_q;
            endcase
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request FSM: every request is followed by at least one IDLE cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pending_q != '0) state_next = REQ;
            REQ:     if (bus.drop_ack)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    assign bus.drop_req = (state == REQ);
    assign bus.pending  = pending_q;
    assign bus.overrun  = overrun_q;

endmodule
